// File: rtl/dsp_seq_pkg.sv
// Shared types and slice control encodings for the DSP MAC sequencer.
// Latency: n/a (constants, types and a pure decode function only).
// Backpressure: n/a.
// Contents: FSM state encoding, OPMODE X/Y/Z selects, ALUMODE ops and the
// Z-select decode for a product that reaches the P stage.
package dsp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADC = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // OPMODE = {Z[2:0], Y[1:0], X[1:0]}; X=Y=01 routes the multiplier output.
  localparam logic [6:0] OPM_ZERO = 7'b000_00_00;
  localparam logic [6:0] OPM_M    = 7'b000_01_01;  // P = 0 + M
  localparam logic [6:0] OPM_C_M  = 7'b011_01_01;  // P = C + M
  localparam logic [6:0] OPM_P_M  = 7'b010_01_01;  // P = P + M
  localparam logic [6:0] OPM_C    = 7'b011_00_00;  // P = C

  localparam logic [3:0] ALU_ADD  = 4'b0000;       // Z + (X + Y)
  localparam logic [3:0] ALU_ZSUB = 4'b0011;       // Z - (X + Y)

  // Only the first product of a job may replace P; later ones accumulate.
  function automatic logic [6:0] cep_opmode(input logic first, input logic addc);
    if (!first) return OPM_P_M;
    return addc ? OPM_C_M : OPM_M;
  endfunction

endpackage

// File: rtl/dsp_seq_token_pipe.sv
// Token delay line mirroring the slice's A/B->M->P pipeline, one token per product.
// Latency: a token pushed in cycle t yields cem in t+PIPE_DLY-1 and cep in t+PIPE_DLY.
// Backpressure: none; the slice pipeline cannot stall, so neither does this.
// Ports: CLK, RST (sync, active-high); push/push_first in; cem, cep, cep_first
// taps out; upstream_busy = tokens still behind the P stage.
import dsp_seq_pkg::*;

module dsp_seq_token_pipe #(
  parameter int PIPE_DLY = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic push,
  input  logic push_first,
  output logic cem,
  output logic cep,
  output logic cep_first,
  output logic upstream_busy
);

  // With PIPE_DLY=1 the M and P stages collapse onto the same tap.
  localparam int M_TAP = (PIPE_DLY > 1) ? PIPE_DLY - 2 : 0;
  localparam int P_TAP = PIPE_DLY - 1;

  logic [PIPE_DLY-1:0] vld_q;
  logic [PIPE_DLY-1:0] first_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q   <= '0;
      first_q <= '0;
    end else begin
      vld_q[0]   <= push;
      first_q[0] <= push & push_first;
      for (int i = 1; i < PIPE_DLY; i++) begin
        vld_q[i]   <= vld_q[i-1];
        first_q[i] <= first_q[i-1];
      end
    end
  end

  assign cem       = vld_q[M_TAP];
  assign cep       = vld_q[P_TAP];
  assign cep_first = first_q[P_TAP];

  // The token at the P tap completes this cycle, so it does not hold off DONE.
  always_comb begin
    upstream_busy = 1'b0;
    for (int i = 0; i < P_TAP; i++) upstream_busy = upstream_busy | vld_q[i];
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP slice through P = [C] + sum A[i]*B[i] (or C - sum with DSP_SEQ_SUB_EN).
// Latency: gap-free job with no C seed reaches DONE LEN+PIPE_DLY+1 cycles after command accept.
// Backpressure: CMD_READY only in IDLE, OP_READY only while operands remain, DONE holds until RES_READY.
// Ports: CLK/RST; CMD_VALID/CMD_READY/CMD_LEN/CMD_ADDC[/CMD_SUB] job request; OP_VALID/OP_READY
// operand handshake; CEA/CEB/CEC/CEM/CEP/RSTP/OPMODE/ALUMODE slice controls;
// RES_VALID/RES_READY result handshake; BUSY. Macro DSP_SEQ_SUB_EN adds CMD_SUB.
import dsp_seq_pkg::*;

module dsp_mac_sequencer #(
  parameter int LEN_W    = 8,
  parameter int PIPE_DLY = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [LEN_W-1:0] CMD_LEN,
  input  logic             CMD_ADDC,
`ifdef DSP_SEQ_SUB_EN
  input  logic             CMD_SUB,
`endif
  input  logic             OP_VALID,
  output logic             OP_READY,
  output logic             CEA,
  output logic             CEB,
  output logic             CEC,
  output logic             CEM,
  output logic             CEP,
  output logic             RSTP,
  output logic [6:0]       OPMODE,
  output logic [3:0]       ALUMODE,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic             BUSY
);

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_q;
  logic             addc_q;
  logic             rstp_q;   // zero-length job without C: clear P once
  logic             cload_q;  // zero-length job with C: load P from C once
  logic             live;
  logic             op_acc;
  logic             last_op;
  logic             pipe_cem;
  logic             pipe_cep;
  logic             pipe_first;
  logic             pipe_upstream;

  // Every control output is forced inactive while reset is asserted.
  assign live    = ~RST;
  assign op_acc  = OP_VALID & OP_READY;
  assign last_op = (count_q + LEN_W'(1)) == len_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      count_q <= '0;
      addc_q  <= 1'b0;
      rstp_q  <= 1'b0;
      cload_q <= 1'b0;
    end else begin
      rstp_q  <= 1'b0;
      cload_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (CMD_VALID) begin
            len_q   <= CMD_LEN;
            addc_q  <= CMD_ADDC;
            count_q <= '0;
            if (CMD_ADDC) begin
              state_q <= ST_LOADC;
            end else if (CMD_LEN == '0) begin
              // DRAIN with an empty pipe lasts one cycle: the RSTP cycle.
              rstp_q  <= 1'b1;
              state_q <= ST_DRAIN;
            end else begin
              state_q <= ST_ACCUM;
            end
          end
        end
        ST_LOADC: begin
          if (len_q == '0) begin
            cload_q <= 1'b1;
            state_q <= ST_DRAIN;
          end else begin
            state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (op_acc) begin
            count_q <= count_q + LEN_W'(1);
            if (last_op) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!pipe_upstream) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (RES_READY) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dsp_seq_token_pipe #(
    .PIPE_DLY(PIPE_DLY)
  ) u_token_pipe (
    .CLK          (CLK),
    .RST          (RST),
    .push         (op_acc),
    .push_first   (count_q == '0),
    .cem          (pipe_cem),
    .cep          (pipe_cep),
    .cep_first    (pipe_first),
    .upstream_busy(pipe_upstream)
  );

  assign CMD_READY = live & (state_q == ST_IDLE);
  assign OP_READY  = live & (state_q == ST_ACCUM) & (count_q < len_q);
  assign CEA       = op_acc;
  assign CEB       = op_acc;
  assign CEC       = live & (state_q == ST_LOADC);
  assign CEM       = live & pipe_cem;
  assign CEP       = live & (pipe_cep | cload_q);
  assign RSTP      = RST | rstp_q;
  assign RES_VALID = live & (state_q == ST_DONE);
  assign BUSY      = live & (state_q != ST_IDLE);

  always_comb begin
    OPMODE = OPM_ZERO;
    if (live) begin
      if (pipe_cep)     OPMODE = cep_opmode(pipe_first, addc_q);
      else if (cload_q) OPMODE = OPM_C;
    end
  end

`ifdef DSP_SEQ_SUB_EN
  logic sub_q;

  always_ff @(posedge CLK) begin
    if (RST)                                  sub_q <= 1'b0;
    else if (state_q == ST_IDLE && CMD_VALID) sub_q <= CMD_SUB;
  end

  assign ALUMODE = (CEP && sub_q) ? ALU_ZSUB : ALU_ADD;
`else
  assign ALUMODE = ALU_ADD;
`endif

endmodule
